// File: rtl/processing_unit_mc.sv
// Multi-cycle processing unit: register file, operand muxing, extended ALU with
// shift-add multiply, registered result, condition codes and register write-back.
//
// state | meaning
// IDLE  | no result pending, ready to accept an op
// EXEC  | o_ToBus holds a fresh result (o_valid high), ready to accept another op
// MUL   | shift-add multiply in progress, not ready
module processing_unit_mc #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 5,
    parameter int MUL_EN     = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_Reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_ALUK,
    input  logic [REG_ADDR_W-1:0] i_SR1_Addr,
    input  logic [REG_ADDR_W-1:0] i_SR2_Addr,
    input  logic                  i_Imm_Sel,
    input  logic [IMM_W-1:0]      i_Imm,
    input  logic [REG_ADDR_W-1:0] i_DR_Addr,
    input  logic                  i_WB,
    input  logic                  i_LD_REG,
    input  logic [REG_ADDR_W-1:0] i_LD_Addr,
    input  logic [DATA_W-1:0]     i_bus,
    output logic [DATA_W-1:0]     o_SR1_Out,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_ToBus,
    output logic [2:0]            o_NZP
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int SH_W     = $clog2(DATA_W);
    localparam int CNT_W    = $clog2(DATA_W) + 1;
    localparam bit MUL_ON   = (MUL_EN != 0);

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];
    logic [DATA_W-1:0]       regs_d [NUM_REGS];
    logic [DATA_W-1:0]       result_q, result_d;
    logic [2:0]              nzp_q, nzp_d;
    logic [DATA_W-1:0]       mcand_q, mcand_d;
    logic [DATA_W-1:0]       mplier_q, mplier_d;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0]   dr_q, dr_d;
    logic                    wb_q, wb_d;

    logic                    accept;
    logic                    is_mul;
    logic [DATA_W-1:0]       op_a, op_b, alu_res, mul_step, res_val;
    logic [SH_W-1:0]         sh;
    logic                    res_we, publish;
    logic [REG_ADDR_W-1:0]   res_addr;

    assign o_ready   = (state_q != MUL);
    assign o_valid   = (state_q == EXEC);
    assign o_ToBus   = result_q;
    assign o_NZP     = nzp_q;
    assign o_SR1_Out = regs_q[i_SR1_Addr];

    assign accept = i_valid && o_ready;
    assign is_mul = MUL_ON && (i_ALUK == 3'b111);
    assign op_a   = regs_q[i_SR1_Addr];
    assign op_b   = i_Imm_Sel ? {{(DATA_W-IMM_W){i_Imm[IMM_W-1]}}, i_Imm} : regs_q[i_SR2_Addr];
    assign sh     = op_b[SH_W-1:0];
    assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = '0;
        case (i_ALUK)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a & op_b;
            3'b010:  alu_res = ~op_a;
            3'b011:  alu_res = op_a;
            3'b100:  alu_res = op_a << sh;
            3'b101:  alu_res = op_a >> sh;
            3'b110:  alu_res = DATA_W'($signed(op_a) >>> sh);
            default: alu_res = '0;  // MUL with the multiplier disabled
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dr_d     = dr_q;
        wb_d     = wb_q;
        res_we   = 1'b0;
        publish  = 1'b0;
        res_addr = i_DR_Addr;
        res_val  = alu_res;
        case (state_q)
            IDLE, EXEC: begin
                state_d = IDLE;
                if (accept) begin
                    if (is_mul) begin
                        state_d  = MUL;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(DATA_W);
                        dr_d     = i_DR_Addr;
                        wb_d     = i_WB;
                    end else begin
                        state_d = EXEC;
                        publish = 1'b1;
                        res_we  = i_WB;
                    end
                end
            end
            MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = EXEC;
                    publish  = 1'b1;
                    res_val  = mul_step;
                    res_we   = wb_q;
                    res_addr = dr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (publish) begin
            result_d = res_val;
            nzp_d    = {res_val[DATA_W-1], res_val == '0, !res_val[DATA_W-1] && (res_val != '0)};
        end
    end

    // Bus load is applied last so it wins over a result write to the same register.
    always_comb begin
        regs_d = regs_q;
        if (res_we) regs_d[res_addr] = res_val;
        if (i_LD_REG) regs_d[i_LD_Addr] = i_bus;
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            nzp_q    <= 3'b010;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dr_q     <= '0;
            wb_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dr_q     <= dr_d;
            wb_q     <= wb_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end
endmodule

// File: tb/tb_processing_unit_mc.sv
// Directed bench for processing_unit_mc: expected results are queued when an op is
// driven and checked by a monitor whenever o_valid is seen.
module tb_processing_unit_mc;
    localparam int DW = 16;

    logic          i_CLK = 1'b0;
    logic          i_Reset;
    logic          i_valid;
    logic          o_ready;
    logic [2:0]    i_ALUK;
    logic [2:0]    i_SR1_Addr, i_SR2_Addr, i_DR_Addr, i_LD_Addr;
    logic          i_Imm_Sel, i_WB, i_LD_REG;
    logic [4:0]    i_Imm;
    logic [DW-1:0] i_bus, o_SR1_Out, o_ToBus;
    logic          o_valid;
    logic [2:0]    o_NZP;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW+2:0] sb [$];

    always #5 i_CLK = ~i_CLK;

    processing_unit_mc #(.DATA_W(16), .REG_ADDR_W(3), .IMM_W(5), .MUL_EN(1)) dut (
        .i_CLK(i_CLK), .i_Reset(i_Reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUK(i_ALUK), .i_SR1_Addr(i_SR1_Addr), .i_SR2_Addr(i_SR2_Addr),
        .i_Imm_Sel(i_Imm_Sel), .i_Imm(i_Imm), .i_DR_Addr(i_DR_Addr), .i_WB(i_WB),
        .i_LD_REG(i_LD_REG), .i_LD_Addr(i_LD_Addr), .i_bus(i_bus),
        .o_SR1_Out(o_SR1_Out), .o_valid(o_valid), .o_ToBus(o_ToBus), .o_NZP(o_NZP)
    );

    // Scoreboard monitor: every o_valid pulse must match the oldest queued result.
    always @(negedge i_CLK) begin
        logic [DW+2:0] exp_e;
        if (i_Reset === 1'b1 && o_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_valid observed=o_valid=1 expected=no result pending (ToBus=%h)", o_ToBus);
            end
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                n_cmp++;
                assert (o_ToBus === exp_e[DW+2:3]) else begin
                    n_bad++;
                    $error("FAIL result observed=%h expected=%h", o_ToBus, exp_e[DW+2:3]);
                end
                n_cmp++;
                assert (o_NZP === exp_e[2:0]) else begin
                    n_bad++;
                    $error("FAIL nzp observed=%b expected=%b", o_NZP, exp_e[2:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [DW-1:0] exp_v);
        i_SR1_Addr = a;
        #1;
        chk($sformatf("reg%0d", a), o_SR1_Out, exp_v);
    endtask

    task automatic load(input logic [2:0] a, input logic [DW-1:0] d);
        i_LD_REG  = 1'b1;
        i_LD_Addr = a;
        i_bus     = d;
        tick();
        i_LD_REG  = 1'b0;
    endtask

    task automatic drive_op(input logic [2:0] aluk, input logic [2:0] sr1, input logic [2:0] sr2,
                            input logic imm_sel, input logic [4:0] imm, input logic [2:0] dr,
                            input logic wb);
        i_valid    = 1'b1;
        i_ALUK     = aluk;
        i_SR1_Addr = sr1;
        i_SR2_Addr = sr2;
        i_Imm_Sel  = imm_sel;
        i_Imm      = imm;
        i_DR_Addr  = dr;
        i_WB       = wb;
    endtask

    function automatic logic [DW+2:0] ent(input logic [DW-1:0] r, input logic [2:0] nzp);
        return {r, nzp};
    endfunction

    initial begin
        i_Reset = 1'b0; i_valid = 1'b0; i_ALUK = '0; i_SR1_Addr = '0; i_SR2_Addr = '0;
        i_Imm_Sel = 1'b0; i_Imm = '0; i_DR_Addr = '0; i_WB = 1'b0; i_LD_REG = 1'b0;
        i_LD_Addr = '0; i_bus = '0;
        repeat (2) tick();
        chk("rst_ready", 16'(o_ready), 16'h1);
        chk("rst_valid", 16'(o_valid), 16'h0);
        chk("rst_nzp", 16'(o_NZP), 16'h2);
        chk("rst_tobus", o_ToBus, 16'h0);
        for (int r = 0; r < 8; r++) check_reg(3'(r), 16'h0);
        @(negedge i_CLK);
        i_Reset = 1'b1;
        tick();

        load(3'd1, 16'h0005);
        load(3'd2, 16'hFFFD);

        // Back-to-back ADD, AND imm, NOT with i_valid held.
        drive_op(3'b000, 3'd1, 3'd2, 1'b0, 5'h00, 3'd3, 1'b1);
        sb.push_back(ent(16'h0002, 3'b001));
        tick();
        drive_op(3'b001, 3'd1, 3'd0, 1'b1, 5'b10000, 3'd0, 1'b1);
        sb.push_back(ent(16'h0000, 3'b010));
        tick();
        drive_op(3'b010, 3'd1, 3'd0, 1'b0, 5'h00, 3'd4, 1'b1);
        sb.push_back(ent(16'hFFFA, 3'b100));
        tick();
        i_valid = 1'b0;
        check_reg(3'd3, 16'h0002);
        check_reg(3'd4, 16'hFFFA);
        tick();

        load(3'd5, 16'h8000);
        load(3'd6, 16'h0001);
        load(3'd7, 16'h0013);
        drive_op(3'b110, 3'd5, 3'd0, 1'b1, 5'd4, 3'd0, 1'b0);
        sb.push_back(ent(16'hF800, 3'b100));
        tick();
        drive_op(3'b101, 3'd5, 3'd0, 1'b1, 5'd4, 3'd5, 1'b0);
        sb.push_back(ent(16'h0800, 3'b001));
        tick();
        drive_op(3'b100, 3'd6, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
        sb.push_back(ent(16'h0008, 3'b001));
        tick();
        i_valid = 1'b0;
        check_reg(3'd5, 16'h8000);
        check_reg(3'd0, 16'h0000);
        tick();

        // MUL 7 * 0xFFFE with a competing request held during the busy window.
        load(3'd1, 16'h0007);
        load(3'd2, 16'hFFFE);
        drive_op(3'b111, 3'd1, 3'd2, 1'b0, 5'd0, 3'd3, 1'b1);
        sb.push_back(ent(16'hFFF2, 3'b100));
        tick();
        drive_op(3'b000, 3'd1, 3'd1, 1'b0, 5'd0, 3'd6, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge i_CLK);
            chk($sformatf("mul_busy_ready_c%0d", k), 16'(o_ready), 16'h0);
            chk($sformatf("mul_busy_valid_c%0d", k), 16'(o_valid), 16'h0);
            if (k == 16) i_valid = 1'b0;
            tick();
        end
        @(negedge i_CLK);
        chk("mul_valid_c17", 16'(o_valid), 16'h1);
        chk("mul_ready_c17", 16'(o_ready), 16'h1);
        tick();
        check_reg(3'd3, 16'hFFF2);
        check_reg(3'd6, 16'h0001);
        tick();

        // Same-edge result write and bus load to R4; then different addresses.
        load(3'd5, 16'h1111);
        drive_op(3'b011, 3'd5, 3'd0, 1'b0, 5'd0, 3'd4, 1'b1);
        i_LD_REG = 1'b1; i_LD_Addr = 3'd4; i_bus = 16'h2222;
        sb.push_back(ent(16'h1111, 3'b001));
        tick();
        drive_op(3'b011, 3'd5, 3'd0, 1'b0, 5'd0, 3'd6, 1'b1);
        i_LD_REG = 1'b1; i_LD_Addr = 3'd7; i_bus = 16'h3333;
        sb.push_back(ent(16'h1111, 3'b001));
        tick();
        i_valid = 1'b0; i_LD_REG = 1'b0;
        check_reg(3'd4, 16'h2222);
        check_reg(3'd6, 16'h1111);
        check_reg(3'd7, 16'h3333);
        tick();

        // Reset in cycle 8 of a MUL: the multiply must be abandoned silently.
        drive_op(3'b111, 3'd1, 3'd2, 1'b0, 5'd0, 3'd3, 1'b1);
        tick();
        i_valid = 1'b0;
        repeat (7) tick();
        i_Reset = 1'b0;
        #2;
        chk("mulrst_valid", 16'(o_valid), 16'h0);
        chk("mulrst_ready", 16'(o_ready), 16'h1);
        repeat (2) tick();
        i_Reset = 1'b1;
        chk("mulrst_nzp", 16'(o_NZP), 16'h2);
        chk("mulrst_tobus", o_ToBus, 16'h0);
        for (int r = 0; r < 8; r++) check_reg(3'(r), 16'h0);
        @(negedge i_CLK);
        chk("mulrst_ready_after", 16'(o_ready), 16'h1);
        repeat (24) tick();
        @(negedge i_CLK);
        #1;
        n_cmp++;
        assert (sb.size() === 0) else begin
            n_bad++;
            $error("FAIL missing_results observed=%0d pending expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
